weight_update_scheduler: RTL and testbench

WEIGHT_UPDATE_SCHEDULER -- requirements
Module: weight_update_scheduler

---
 rtl/weight_update_scheduler_pkg.sv | 10 +
 rtl/weight_update_scheduler_update_fifo.sv | 41 ++++
 rtl/weight_update_scheduler.sv | 87 ++++++++
 tb/tb_weight_update_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_update_scheduler_pkg.sv
// weight_update_scheduler_pkg: shared types and sizing for the weight-update scheduler.
package weight_update_scheduler_pkg;
  typedef enum logic {IDLE, WRBACK} state_t;
  localparam int ROW_W = 8;
  localparam int GHR_W = 20;
  localparam int WAYS = 4;
  localparam int ENTRY_W = ROW_W + GHR_W;
  localparam int QDEPTH_DEF = 4;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/weight_update_scheduler_update_fifo.sv
// update_fifo: synchronous FIFO of pending {row, history} training requests.
module update_fifo
  import weight_update_scheduler_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF,
  parameter int W = ENTRY_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic w_do_push;
  logic w_do_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop = i_pop && !o_empty;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/weight_update_scheduler.sv
// weight_update_scheduler: arbitrates weight-table port between prediction lookups
// and queued training writebacks, with a starvation bound on pending updates.
module weight_update_scheduler
  import weight_update_scheduler_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  i_fire,
  input  logic                  rst,
  input  logic                  i_predReq,
  input  logic [WAYS*ROW_W-1:0] i_predAddr_32,
  output logic                  o_predGrant,
  output logic                  o_predValid,
  input  logic                  i_updValid,
  input  logic [ROW_W-1:0]      i_updPos_8,
  input  logic [GHR_W-1:0]      i_updGhr_20,
  output logic                  o_updReady,
  output logic                  o_readEn,
  output logic [WAYS*ROW_W-1:0] o_readAddr_32,
  output logic                  o_writeEn,
  output logic [ROW_W-1:0]      o_writeAddr_8,
  output logic [GHR_W-1:0]      o_trainGhr_20,
  output logic                  o_updDone
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  state_t r_state;
  logic [SW-1:0] r_starve;
  logic [ROW_W-1:0] r_pos;
  logic [GHR_W-1:0] r_ghr;
  logic r_pred_valid;
  logic w_full;
  logic w_empty;
  logic [ENTRY_W-1:0] w_head;
  logic [ROW_W-1:0] w_head_pos;
  logic w_idle;
  logic w_forced;
  logic w_grant;
  logic w_pop;
  logic w_push;
  logic w_wb;
  update_fifo #(.DEPTH(QDEPTH), .W(ENTRY_W)) u_fifo (
    .i_clk   (i_fire),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  ({i_updPos_8, i_updGhr_20}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign w_head_pos = w_head[ENTRY_W-1 -: ROW_W];
  // Grants are combinational on the request, so they are gated by reset directly.
  assign w_idle = rst && (r_state == IDLE);
  assign w_forced = !w_empty && (r_starve == SMAX);
  assign w_grant = w_idle && !w_forced && i_predReq;
  assign w_pop = w_idle && !w_grant && !w_empty;
  assign w_push = i_updValid && o_updReady;
  assign w_wb = r_state == WRBACK;
  assign o_updReady = !w_full;
  assign o_predGrant = w_grant;
  assign o_predValid = r_pred_valid;
  assign o_readEn = w_grant || w_pop;
  assign o_readAddr_32 = w_grant ? i_predAddr_32 : w_pop ? {WAYS{w_head_pos}} : '0;
  assign o_writeEn = w_wb;
  assign o_updDone = w_wb;
  assign o_writeAddr_8 = w_wb ? r_pos : '0;
  assign o_trainGhr_20 = w_wb ? r_ghr : '0;
  always_ff @(posedge i_fire or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_starve <= '0;
      r_pos <= '0;
      r_ghr <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      r_pred_valid <= w_grant;
      r_state <= w_pop ? WRBACK : IDLE;
      r_starve <= (w_pop || w_empty) ? '0 : (w_grant && r_starve != SMAX) ? r_starve + 1'b1 : r_starve;
      if (w_pop) begin
        r_pos <= w_head_pos;
        r_ghr <= w_head[GHR_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_weight_update_scheduler.sv
// tb_weight_update_scheduler: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the scheduler.
module tb_weight_update_scheduler;
  localparam int QD = 4;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic i_predReq;
  logic [31:0] i_predAddr_32;
  logic i_updValid;
  logic [7:0] i_updPos_8;
  logic [19:0] i_updGhr_20;
  logic o_predGrant, o_predValid, o_updReady, o_readEn, o_writeEn, o_updDone;
  logic [31:0] o_readAddr_32;
  logic [7:0] o_writeAddr_8;
  logic [19:0] o_trainGhr_20;
  int checks = 0;
  int errors = 0;

  weight_update_scheduler #(.QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .i_fire        (clk),
    .rst           (rst_n),
    .i_predReq     (i_predReq),
    .i_predAddr_32 (i_predAddr_32),
    .o_predGrant   (o_predGrant),
    .o_predValid   (o_predValid),
    .i_updValid    (i_updValid),
    .i_updPos_8    (i_updPos_8),
    .i_updGhr_20   (i_updGhr_20),
    .o_updReady    (o_updReady),
    .o_readEn      (o_readEn),
    .o_readAddr_32 (o_readAddr_32),
    .o_writeEn     (o_writeEn),
    .o_writeAddr_8 (o_writeAddr_8),
    .o_trainGhr_20 (o_trainGhr_20),
    .o_updDone     (o_updDone)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic req, input logic [31:0] addr, input logic uv,
                       input logic [7:0] pos, input logic [19:0] ghr);
    i_predReq = req;
    i_predAddr_32 = addr;
    i_updValid = uv;
    i_updPos_8 = pos;
    i_updGhr_20 = ghr;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 32'hDEADBEEF, 1, 8'h11, 20'h1);
    #2;
    checks++;
    if (o_predGrant !== 1'b0 || o_readEn !== 1'b0 || o_readAddr_32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_read: grant=%b readEn=%b addr=%h, required 0/0/0", o_predGrant, o_readEn, o_readAddr_32);
    end
    checks++;
    if (o_writeEn !== 1'b0 || o_updDone !== 1'b0 || o_predValid !== 1'b0 || o_writeAddr_8 !== 8'h0 || o_trainGhr_20 !== 20'h0) begin
      errors++;
      $display("FAIL reset_write: we=%b done=%b pv=%b wa=%h ghr=%h, required all 0", o_writeEn, o_updDone, o_predValid, o_writeAddr_8, o_trainGhr_20);
    end
    checks++;
    if (o_updReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", o_updReady);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_predict;
    do_reset();
    drive(1, 32'h04030201, 0, 0, 0);
    #2;
    checks++;
    if (o_predGrant !== 1'b1 || o_readEn !== 1'b1 || o_readAddr_32 !== 32'h04030201) begin
      errors++;
      $display("FAIL predict_grant: grant=%b readEn=%b addr=%h, required 1/1/04030201", o_predGrant, o_readEn, o_readAddr_32);
    end
    @(negedge clk);
    drive(0, 32'h04030201, 0, 0, 0);
    #2;
    checks++;
    if (o_predValid !== 1'b1 || o_predGrant !== 1'b0 || o_readAddr_32 !== 32'h0) begin
      errors++;
      $display("FAIL predict_valid: pv=%b grant=%b addr=%h, required 1/0/0", o_predValid, o_predGrant, o_readAddr_32);
    end
    @(negedge clk);
    #2;
    checks++;
    if (o_predValid !== 1'b0) begin
      errors++;
      $display("FAIL predict_valid_drop: got %b required 0", o_predValid);
    end
  endtask

  task automatic test_update;
    do_reset();
    drive(0, 0, 1, 8'h2A, 20'h00001);
    #2;
    checks++;
    if (o_updReady !== 1'b1 || o_readEn !== 1'b0) begin
      errors++;
      $display("FAIL update_push: ready=%b readEn=%b, required 1/0", o_updReady, o_readEn);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #2;
    checks++;
    if (o_readEn !== 1'b1 || o_readAddr_32 !== 32'h2A2A2A2A || o_writeEn !== 1'b0) begin
      errors++;
      $display("FAIL update_read: readEn=%b addr=%h we=%b, required 1/2a2a2a2a/0", o_readEn, o_readAddr_32, o_writeEn);
    end
    @(negedge clk);
    #2;
    checks++;
    if (o_writeEn !== 1'b1 || o_writeAddr_8 !== 8'h2A || o_trainGhr_20 !== 20'h00001 || o_updDone !== 1'b1 || o_readEn !== 1'b0) begin
      errors++;
      $display("FAIL update_write: we=%b wa=%h ghr=%h done=%b readEn=%b, required 1/2a/00001/1/0", o_writeEn, o_writeAddr_8, o_trainGhr_20, o_updDone, o_readEn);
    end
    @(negedge clk);
    #2;
    checks++;
    if (o_writeEn !== 1'b0 || o_updDone !== 1'b0 || o_writeAddr_8 !== 8'h0 || o_trainGhr_20 !== 20'h0 || o_readEn !== 1'b0) begin
      errors++;
      $display("FAIL update_idle: we=%b done=%b wa=%h ghr=%h readEn=%b, required all 0", o_writeEn, o_updDone, o_writeAddr_8, o_trainGhr_20, o_readEn);
    end
  endtask

  task automatic test_starve;
    logic [7:0] exp_g;
    exp_g = 8'b1100_1111;
    do_reset();
    drive(1, 32'h0A0B0C0D, 1, 8'h33, 20'h3);
    #2;
    checks++;
    if (o_predGrant !== 1'b1) begin
      errors++;
      $display("FAIL starve_first: grant=%b required 1", o_predGrant);
    end
    @(negedge clk);
    drive(1, 32'h0A0B0C0D, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      #2;
      checks++;
      if (o_predGrant !== exp_g[c]) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got %b required %b", c, o_predGrant, exp_g[c]);
      end
      if (c == 5) begin
        checks++;
        if (o_writeEn !== 1'b1 || o_writeAddr_8 !== 8'h33) begin
          errors++;
          $display("FAIL starve_write: we=%b wa=%h required 1/33", o_writeEn, o_writeAddr_8);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full;
    logic [6:0] exp_r;
    int acc;
    exp_r = 7'b100_1111;
    acc = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1, 32'h01010101, 1, 8'h50 + 8'(acc), 20'(acc));
      #2;
      checks++;
      if (o_updReady !== exp_r[c]) begin
        errors++;
        $display("FAIL full_ready[%0d]: got %b required %b", c, o_updReady, exp_r[c]);
      end
      if (c == 5) begin
        checks++;
        if (o_readAddr_32 !== 32'h50505050 || o_predGrant !== 1'b0) begin
          errors++;
          $display("FAIL full_pop: addr=%h grant=%b required 50505050/0", o_readAddr_32, o_predGrant);
        end
      end
      if (o_updReady) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc != 5) begin
      errors++;
      $display("FAIL full_accepted: got %0d required 5", acc);
    end
    drive(0, 0, 0, 0, 0);
    #2;
    checks++;
    if (o_updReady !== 1'b0 || o_readAddr_32 !== 32'h51515151) begin
      errors++;
      $display("FAIL full_after: ready=%b addr=%h required 0/51515151", o_updReady, o_readAddr_32);
    end
    @(negedge clk);
  endtask

  task automatic test_same_row;
    logic [5:0] exp_rd, exp_wr;
    int wbs;
    exp_rd = 6'b001010;
    exp_wr = 6'b010100;
    wbs = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, c < 2, 8'h10, c == 0 ? 20'hAAAAA : 20'h55555);
      #2;
      checks++;
      if (o_readEn !== exp_rd[c] || o_writeEn !== exp_wr[c] || (o_readEn && o_readAddr_32 !== 32'h10101010)) begin
        errors++;
        $display("FAIL same_row[%0d]: readEn=%b we=%b addr=%h required %b/%b", c, o_readEn, o_writeEn, o_readAddr_32, exp_rd[c], exp_wr[c]);
      end
      if (o_writeEn) begin
        checks++;
        if (o_writeAddr_8 !== 8'h10 || o_trainGhr_20 !== (wbs == 0 ? 20'hAAAAA : 20'h55555)) begin
          errors++;
          $display("FAIL same_row_wb%0d: wa=%h ghr=%h", wbs, o_writeAddr_8, o_trainGhr_20);
        end
        wbs++;
      end
      @(negedge clk);
    end
    checks++;
    if (wbs != 2) begin
      errors++;
      $display("FAIL same_row_count: got %0d required 2", wbs);
    end
  endtask

  task automatic test_reset_wrback;
    do_reset();
    drive(0, 0, 1, 8'h77, 20'h7);
    @(negedge clk);
    drive(0, 0, 1, 8'h78, 20'h8);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #2;
    checks++;
    if (o_writeEn !== 1'b1 || o_writeAddr_8 !== 8'h77) begin
      errors++;
      $display("FAIL rstwb_pre: we=%b wa=%h required 1/77", o_writeEn, o_writeAddr_8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_writeEn !== 1'b0 || o_updDone !== 1'b0 || o_writeAddr_8 !== 8'h0) begin
      errors++;
      $display("FAIL rstwb_abort: we=%b done=%b wa=%h required 0/0/0", o_writeEn, o_updDone, o_writeAddr_8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (o_updReady !== 1'b1 || o_readEn !== 1'b0 || o_writeEn !== 1'b0) begin
        errors++;
        $display("FAIL rstwb_empty[%0d]: ready=%b readEn=%b we=%b required 1/0/0", c, o_updReady, o_readEn, o_writeEn);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [27:0] q[$];
    logic [27:0] lat;
    logic [7:0] hp;
    bit wb, pg, forced, eg, ep, er, nonempty;
    int starve;
    logic [31:0] ea;
    logic req, uv;
    logic [31:0] addr;
    logic [7:0] pos;
    logic [19:0] ghr;
    wb = 0;
    pg = 0;
    starve = 0;
    lat = '0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req = $urandom_range(0, 9) < 7;
      uv = $urandom_range(0, 1);
      addr = $urandom;
      pos = 8'($urandom);
      ghr = 20'($urandom);
      drive(req, addr, uv, pos, ghr);
      er = q.size() < QD;
      forced = q.size() > 0 && starve >= SM;
      eg = !wb && !forced && req;
      ep = !wb && !eg && q.size() > 0;
      hp = q.size() > 0 ? q[0][27:20] : 8'h0;
      ea = eg ? addr : ep ? {hp, hp, hp, hp} : 32'h0;
      #2;
      checks++;
      if (o_predGrant !== eg || o_readEn !== (eg || ep) || o_readAddr_32 !== ea) begin
        errors++;
        $display("FAIL rand_read@%0d: grant=%b readEn=%b addr=%h required %b/%b/%h", c, o_predGrant, o_readEn, o_readAddr_32, eg, eg || ep, ea);
      end
      checks++;
      if (o_writeEn !== wb || o_updDone !== wb || o_writeAddr_8 !== (wb ? lat[27:20] : 8'h0) || o_trainGhr_20 !== (wb ? lat[19:0] : 20'h0)) begin
        errors++;
        $display("FAIL rand_write@%0d: we=%b done=%b wa=%h ghr=%h required wb=%b entry=%h", c, o_writeEn, o_updDone, o_writeAddr_8, o_trainGhr_20, wb, lat);
      end
      checks++;
      if (o_updReady !== er || o_predValid !== pg) begin
        errors++;
        $display("FAIL rand_status@%0d: ready=%b pv=%b required %b/%b", c, o_updReady, o_predValid, er, pg);
      end
      nonempty = q.size() > 0;
      if (ep) lat = q.pop_front();
      wb = ep;
      if (uv && er) q.push_back({pos, ghr});
      if (ep || !nonempty) starve = 0;
      else if (eg && starve < SM) starve++;
      pg = eg;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_predict();
    test_update();
    test_starve();
    test_full();
    test_same_row();
    test_reset_wrback();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
